// File: rtl/housekeeping_reg_arbiter.sv
// rtl/housekeeping_reg_arbiter.sv - shares the housekeeping register file between SPI strobes and a Wishbone port
// Optional round-robin SPI/Wishbone arbitration: define HK_ARB_FAIR_EN.
module housekeeping_reg_arbiter #(
    parameter int SYNC_STAGES  = 2,
    parameter int SPI_PRIORITY = 1
) (
    input  logic       wb_clk_i,
    input  logic       wb_rstn_i,
    input  logic       spi_rdstb,
    input  logic       spi_wrstb,
    input  logic [7:0] spi_addr,
    input  logic [7:0] spi_wdata,
    output logic [7:0] spi_rdata,
    output logic       spi_busy,
    output logic       spi_overrun,
    input  logic       wb_req,
    input  logic       wb_we,
    input  logic [7:0] wb_addr,
    input  logic [7:0] wb_wdata,
    output logic       wb_ack,
    output logic [7:0] wb_rdata,
    output logic [7:0] reg_addr,
    output logic       reg_re,
    output logic       reg_we,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    input  logic       ovr_clr
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] rd_sync, wr_sync;
    logic                   rd_prev, wr_prev;
    logic                   rd_rise, wr_rise;
    logic                   rd_pend, wr_pend;
    logic                   overrun_q;
    logic                   grant_spi, acc_we;
    logic [7:0]             acc_addr, acc_wdata;
    logic [7:0]             spi_rdata_q, wb_rdata_q;
    logic                   spi_any, spi_first, pick_spi, pick_wb, start;
    logic                   take_rd, take_wr;

    assign rd_rise = rd_sync[SYNC_STAGES-1] & ~rd_prev;
    assign wr_rise = wr_sync[SYNC_STAGES-1] & ~wr_prev;
    assign spi_any = rd_pend | wr_pend;

`ifdef HK_ARB_FAIR_EN
    logic last_winner;   // 1: SPI won the last tie

    assign spi_first = ~last_winner;

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i)
            last_winner <= 1'b0;
        else if (start && spi_any && wb_req)
            last_winner <= pick_spi;
    end
`else
    assign spi_first = (SPI_PRIORITY != 0);
`endif

    always_comb begin
        pick_spi = spi_any & (~wb_req | spi_first);
        pick_wb  = wb_req & ~pick_spi;
        start    = (state == IDLE) & (pick_spi | pick_wb);
        // SPI write is served before a pending SPI read
        take_wr  = start & pick_spi & wr_pend;
        take_rd  = start & pick_spi & ~wr_pend;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            rd_sync   <= '0;
            wr_sync   <= '0;
            rd_prev   <= 1'b0;
            wr_prev   <= 1'b0;
            rd_pend   <= 1'b0;
            wr_pend   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rd_sync   <= {rd_sync[SYNC_STAGES-2:0], spi_rdstb};
            wr_sync   <= {wr_sync[SYNC_STAGES-2:0], spi_wrstb};
            rd_prev   <= rd_sync[SYNC_STAGES-1];
            wr_prev   <= wr_sync[SYNC_STAGES-1];
            rd_pend   <= (rd_pend & ~take_rd) | (rd_rise & ~rd_pend);
            wr_pend   <= (wr_pend & ~take_wr) | (wr_rise & ~wr_pend);
            overrun_q <= (overrun_q & ~ovr_clr) | (rd_rise & rd_pend) | (wr_rise & wr_pend);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_spi || pick_wb) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            grant_spi   <= 1'b0;
            acc_we      <= 1'b0;
            acc_addr    <= 8'h00;
            acc_wdata   <= 8'h00;
            spi_rdata_q <= 8'h00;
            wb_rdata_q  <= 8'h00;
        end else begin
            if (start) begin
                grant_spi <= pick_spi;
                acc_we    <= pick_spi ? wr_pend   : wb_we;
                acc_addr  <= pick_spi ? spi_addr  : wb_addr;
                acc_wdata <= pick_spi ? spi_wdata : wb_wdata;
            end
            if (state == RESP && !acc_we) begin
                if (grant_spi)
                    spi_rdata_q <= reg_rdata;
                else
                    wb_rdata_q  <= reg_rdata;
            end
        end
    end

    // Read data is forwarded combinationally during RESP so it is valid in the ack cycle
    assign reg_re      = (state == ACCESS) & ~acc_we;
    assign reg_we      = (state == ACCESS) & acc_we;
    assign reg_addr    = acc_addr;
    assign reg_wdata   = acc_wdata;
    assign wb_ack      = (state == RESP) & ~grant_spi;
    assign wb_rdata    = (wb_ack && !acc_we) ? reg_rdata : wb_rdata_q;
    assign spi_rdata   = (state == RESP && grant_spi && !acc_we) ? reg_rdata : spi_rdata_q;
    assign spi_busy    = spi_any | ((state != IDLE) & grant_spi);
    assign spi_overrun = overrun_q;

endmodule

// File: tb/tb_housekeeping_reg_arbiter.sv
// tb/tb_housekeeping_reg_arbiter.sv - self-checking bench for housekeeping_reg_arbiter
module tb_housekeeping_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_rdstb, spi_wrstb;
    logic [7:0] spi_addr, spi_wdata, spi_rdata;
    logic       spi_busy, spi_overrun;
    logic       wb_req, wb_we, wb_ack;
    logic [7:0] wb_addr, wb_wdata, wb_rdata;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_re, reg_we;
    logic       ovr_clr;

    logic [7:0]  mem [256];
    logic [7:0]  shadow [256];
    logic [16:0] acc_q [$];
    logic        pl_en;
    logic [7:0]  pl_addr, pl_data;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    housekeeping_reg_arbiter dut (
        .wb_clk_i(clk), .wb_rstn_i(rst_n),
        .spi_rdstb(spi_rdstb), .spi_wrstb(spi_wrstb), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_rdata(spi_rdata), .spi_busy(spi_busy), .spi_overrun(spi_overrun),
        .wb_req(wb_req), .wb_we(wb_we), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
        .wb_ack(wb_ack), .wb_rdata(wb_rdata),
        .reg_addr(reg_addr), .reg_re(reg_re), .reg_we(reg_we), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .ovr_clr(ovr_clr)
    );

    // Register file model plus a log of every access the DUT performs
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (reg_we) mem[reg_addr] <= reg_wdata;
        if (reg_re) reg_rdata <= mem[reg_addr];
        if (reg_re || reg_we) acc_q.push_back({reg_we, reg_addr, reg_we ? reg_wdata : 8'h00});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (reg_re || reg_we) chk("reg_excl", reg_re & reg_we, 0);
    endtask

    task automatic check_acc(input logic we, input logic [7:0] a, input logic [7:0] d);
        logic [16:0] e;
        chk("acc_present", acc_q.size() != 0, 1);
        if (acc_q.size() != 0) begin
            e = acc_q.pop_front();
            chk("acc", e, {we, a, (we ? d : 8'h00)});
        end
    endtask

    task automatic wb_txn(input logic we, input logic [7:0] a, input logic [7:0] d);
        int n;
        bit got;
        wb_req = 1'b1; wb_we = we; wb_addr = a; wb_wdata = d;
        n = 0; got = 0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (wb_ack) got = 1;
        end
        chk("wb_ack_seen", got, 1);
        chk("wb_latency", n, 2);
        if (!we) chk("wb_rdata_ack", wb_rdata, shadow[a]);
        wb_req = 1'b0;
        tick();
        chk("wb_ack_pulse", wb_ack, 0);
        if (!we) chk("wb_rdata_hold", wb_rdata, shadow[a]);
        else shadow[a] = d;
        check_acc(we, a, d);
    endtask

    task automatic spi_txn(input logic we, input logic [7:0] a, input logic [7:0] d);
        int n;
        spi_addr = a; spi_wdata = d;
        if (we) spi_wrstb = 1'b1; else spi_rdstb = 1'b1;
        repeat (6) tick();
        spi_rdstb = 1'b0; spi_wrstb = 1'b0;
        n = 0;
        while (spi_busy && n < 40) begin tick(); n++; end
        chk("spi_busy_clear", spi_busy, 0);
        if (we) shadow[a] = d;
        else chk("spi_rdata", spi_rdata, shadow[a]);
        check_acc(we, a, d);
        repeat (6) tick();
    endtask

    initial begin
        int ack_c;
        int acks;
        logic [7:0] ra, rd;
        rst_n = 1'b0; spi_rdstb = 0; spi_wrstb = 0; spi_addr = 0; spi_wdata = 0;
        wb_req = 0; wb_we = 0; wb_addr = 0; wb_wdata = 0; ovr_clr = 0;
        pl_en = 0; pl_addr = 0; pl_data = 0;
        for (int i = 0; i < 256; i++) shadow[i] = 8'($urandom);
        shadow[8'h08] = 8'hA5;
        for (int i = 0; i < 256; i++) begin
            pl_en = 1'b1; pl_addr = 8'(i); pl_data = shadow[i];
            tick();
        end
        pl_en = 1'b0;
        chk("reset_outputs", {reg_re, reg_we, wb_ack, spi_busy, spi_overrun, spi_rdata, wb_rdata, reg_addr, reg_wdata}, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_no_access", acc_q.size(), 0);

        wb_txn(1'b1, 8'h0A, 8'h5C);
        wb_txn(1'b0, 8'h0A, 8'h00);

        spi_addr = 8'h08; spi_rdstb = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 3) chk("spi_rd_pre", {reg_re, spi_busy}, 2'b01);
            if (c == 4) chk("spi_rd_re", {reg_re, reg_addr}, {1'b1, 8'h08});
            if (c == 5) chk("spi_rd_data", spi_rdata, 8'hA5);
            if (c == 6) chk("spi_rd_busy", spi_busy, 0);
        end
        spi_rdstb = 1'b0;
        check_acc(1'b0, 8'h08, 8'h00);
        repeat (6) tick();

        spi_addr = 8'h11; spi_wdata = 8'h33; spi_wrstb = 1'b1;
        repeat (3) tick();
        wb_req = 1'b1; wb_we = 1'b0; wb_addr = 8'h10;
        ack_c = -1;
        for (int c = 4; c <= 10; c++) begin
            tick();
            if (c == 4) chk("col_spi_first", {reg_we, reg_addr, reg_wdata}, {1'b1, 8'h11, 8'h33});
            if (wb_ack) begin
                if (ack_c < 0) ack_c = c;
                chk("col_wb_rdata", wb_rdata, shadow[8'h10]);
                wb_req = 1'b0;
            end
            if (c == 6) spi_wrstb = 1'b0;
        end
        chk("col_ack_cycle", ack_c, 8);
        shadow[8'h11] = 8'h33;
        check_acc(1'b1, 8'h11, 8'h33);
        check_acc(1'b0, 8'h10, 8'h00);
        repeat (6) tick();

        spi_addr = 8'h20; spi_wdata = 8'h7E; spi_wrstb = 1'b1; spi_rdstb = 1'b1;
        repeat (6) tick();
        spi_wrstb = 1'b0; spi_rdstb = 1'b0;
        acks = 0;
        while (spi_busy && acks < 40) begin tick(); acks++; end
        chk("simul_busy_clear", spi_busy, 0);
        chk("simul_rdata", spi_rdata, 8'h7E);
        shadow[8'h20] = 8'h7E;
        check_acc(1'b1, 8'h20, 8'h7E);
        check_acc(1'b0, 8'h20, 8'h00);
        repeat (6) tick();

        spi_addr = 8'h55; spi_rdstb = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) begin spi_rdstb = 1'b0; wb_req = 1'b1; wb_we = 1'b0; wb_addr = 8'h40; end
            if (c == 2) spi_rdstb = 1'b1;
            if (c == 3) begin
                chk("ovr_wb_ack", wb_ack, 1);
                wb_req = 1'b0;
                spi_rdstb = 1'b0;
            end
            if (c == 4) chk("ovr_wb_rdata", wb_rdata, shadow[8'h40]);
            if (c == 5) begin
                chk("ovr_spi_re", {reg_re, reg_addr}, {1'b1, 8'h55});
                chk("ovr_flag", spi_overrun, 1);
            end
        end
        chk("ovr_busy_clear", spi_busy, 0);
        chk("ovr_spi_rdata", spi_rdata, shadow[8'h55]);
        check_acc(1'b0, 8'h40, 8'h00);
        check_acc(1'b0, 8'h55, 8'h00);
        chk("ovr_single_read", acc_q.size(), 0);
        repeat (4) tick();
        chk("ovr_sticky", spi_overrun, 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_cleared", spi_overrun, 0);
        repeat (6) tick();

        for (int k = 0; k < 24; k++) begin
            ra = 8'($urandom); rd = 8'($urandom);
            case ($urandom_range(0, 3))
                0: wb_txn(1'b1, ra, rd);
                1: wb_txn(1'b0, ra, 8'h00);
                2: spi_txn(1'b1, ra, rd);
                default: spi_txn(1'b0, ra, 8'h00);
            endcase
        end
        wb_txn(1'b1, 8'hFF, 8'hC3);
        spi_txn(1'b0, 8'hFF, 8'h00);
        spi_txn(1'b1, 8'h00, 8'h3C);
        wb_txn(1'b0, 8'h00, 8'h00);
        chk("no_overrun_in_contract", spi_overrun, 0);

        wb_req = 1'b1; wb_we = 1'b1; wb_addr = 8'h33; wb_wdata = 8'h99;
        tick();
        chk("rst_in_access", reg_we, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_outputs_zero", {reg_re, reg_we, wb_ack, spi_busy, spi_overrun, spi_rdata, wb_rdata, reg_addr, reg_wdata}, 0);
        wb_req = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (wb_ack) acks++;
        end
        chk("rst_no_ack", acks, 0);
        chk("rst_no_write", acc_q.size(), 0);
        chk("rst_mem_intact", mem[8'h33], shadow[8'h33]);
        chk("rst_idle", {spi_busy, reg_re, reg_we}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
